nbout_psum_ctrl: RTL and testbench

NBOUT_PSUM_CTRL -- requirements
Module: nbout_psum_ctrl

---
 rtl/dnn_pkg.sv | 13 +
 rtl/psum_regfile.sv | 25 ++
 rtl/nbout_psum_ctrl.sv | 153 +++++++++++++++
 tb/tb_nbout_psum_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared defaults and FSM encoding for the NBout partial-sum controller.
package dnn_pkg;
  localparam int N_DEF     = 16;
  localparam int TN_DEF    = 16;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/psum_regfile.sv
// DEPTH x W partial-sum storage: one synchronous write port, two combinational read ports.
module psum_regfile #(
  parameter int W     = 256,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_psum_i,
  output logic [W-1:0]  rdata_psum_o,
  input  logic [AW-1:0] raddr_drain_i,
  output logic [W-1:0]  rdata_drain_o
);
  logic [W-1:0] mem_q [DEPTH];

  // No reset: pass 0 never consumes stored data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_psum_o  = mem_q[raddr_psum_i];
  assign rdata_drain_o = mem_q[raddr_drain_i];
endmodule

// File: rtl/nbout_psum_ctrl.sv
// NBout partial-sum sequencer: feeds buffered psums to the cluster, writes results back, then drains.
// Optional NBOUT_RELU_EN clamps negative lanes on the drain stream only.
module nbout_psum_ctrl
  import dnn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Tn    = TN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [$clog2(DEPTH):0]  i_num_groups,
  input  logic [7:0]              i_num_passes,
  input  logic                    i_valid,
  output logic [Tn*N-1:0]         o_psum,
  input  logic [Tn*N-1:0]         i_res,
  output logic [Tn*N-1:0]         o_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = AW + 1;
  localparam int W  = Tn * N;

  state_t        state_q, state_d;
  logic [AW-1:0] g_q, g_d;
  logic [7:0]    p_q, p_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [7:0]    pas_q, pas_d;
  logic [AW-1:0] k_q, k_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] wg_q, wg_d;
  logic          wzero_q, wzero_d;
  logic          done_q, done_d;

  logic [W-1:0]  rd_psum;
  logic [W-1:0]  rd_drain;
  logic          last_g, last_p, last_k;

  assign last_g = ({1'b0, g_q} == grp_q - GW'(1));
  assign last_p = (p_q == pas_q - 8'd1);
  assign last_k = ({1'b0, k_q} == grp_q - GW'(1));

  psum_regfile #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clk           (clk),
    .we_i          (pend_q && !rst),
    .waddr_i       (wg_q),
    .wdata_i       (i_res),
    .raddr_psum_i  (wg_q),
    .rdata_psum_o  (rd_psum),
    .raddr_drain_i (k_q),
    .rdata_drain_o (rd_drain)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    grp_d   = grp_q;
    pas_d   = pas_q;
    k_d     = k_q;
    pend_d  = 1'b0;
    wg_d    = wg_q;
    wzero_d = wzero_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          grp_d   = i_num_groups;
          pas_d   = i_num_passes;
          g_d     = '0;
          p_d     = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        if (i_valid) begin
          pend_d  = 1'b1;
          wg_d    = g_q;
          wzero_d = (p_q == 8'd0);
          if (last_g) begin
            g_d = '0;
            p_d = p_q + 8'd1;
            if (last_p) state_d = ST_FLUSH;
          end else begin
            g_d = g_q + AW'(1);
          end
        end
      end
      // The final writeback lands during the single FLUSH cycle.
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (i_out_ready) begin
          if (last_k) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            k_d     = '0;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      grp_q   <= '0;
      pas_q   <= '0;
      k_q     <= '0;
      pend_q  <= 1'b0;
      wg_q    <= '0;
      wzero_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      grp_q   <= grp_d;
      pas_q   <= pas_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      wg_q    <= wg_d;
      wzero_q <= wzero_d;
      done_q  <= done_d;
    end
  end

  assign o_psum      = (pend_q && !wzero_q) ? rd_psum : '0;
  assign o_out_valid = (state_q == ST_DRAIN);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;

  always_comb begin
    o_out_data = '0;
    if (state_q == ST_DRAIN) begin
      o_out_data = rd_drain;
`ifdef NBOUT_RELU_EN
      for (int l = 0; l < Tn; l++) begin
        if (rd_drain[l*N + N-1]) o_out_data[l*N +: N] = '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Randomized directed bench for nbout_psum_ctrl against a per-group array model.
module tb_nbout_psum_ctrl;
  localparam int N     = 16;
  localparam int TN    = 16;
  localparam int DEPTH = 16;
  localparam int W     = N * TN;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [4:0]   i_num_groups;
  logic [7:0]   i_num_passes;
  logic         i_valid;
  logic [W-1:0] o_psum;
  logic [W-1:0] i_res;
  logic [W-1:0] o_out_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic         o_busy;
  logic         o_done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mdl [DEPTH];
  int           mode;
  int           addc;
  logic [W-1:0] fixed_res;

  always #5 clk = ~clk;

  nbout_psum_ctrl #(.N(N), .Tn(TN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_num_groups (i_num_groups),
    .i_num_passes (i_num_passes),
    .i_valid      (i_valid),
    .o_psum       (o_psum),
    .i_res        (i_res),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] add_lanes(input logic [W-1:0] v, input int c);
    logic [W-1:0] r;
    for (int l = 0; l < TN; l++) r[l*N +: N] = v[l*N +: N] + N'(c);
    return r;
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
`ifdef NBOUT_RELU_EN
    for (int l = 0; l < TN; l++) if (v[l*N + N-1]) r[l*N +: N] = '0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] mk_res(input logic [W-1:0] pe);
    if (mode == 0) return add_lanes(pe, addc);
    if (mode == 1) return rand_word();
    return fixed_res;
  endfunction

  // Runs the compute phase of one job; returns early after `abort` steps if abort > 0.
  task automatic run_job(input int G, input int P, input bit gaps, input int abort);
    int g = 0, p = 0, s = 0, pg = 0;
    bit pend = 0, fin = 0;
    logic [W-1:0] pe, res;
    pe = '0;
    i_start      = 1'b1;
    i_num_groups = 5'(G);
    i_num_passes = 8'(P);
    i_valid      = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    chk1("busy_run", o_busy, 1'b1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (pend) begin
        chk("psum", o_psum, pe);
        res      = mk_res(pe);
        i_res    = res;
        mdl[pg]  = res;
      end else begin
        chk("psum_zero", o_psum, '0);
        i_res = rand_word();
      end
      if (abort > 0 && s == abort) return;
      if (s == G*P && !pend) begin
        fin = 1;
        break;
      end
      i_start = gaps && ($urandom_range(0, 3) == 0);
      i_num_groups = 5'($urandom_range(1, 16));
      pend    = 0;
      i_valid = 1'b0;
      if (s < G*P) begin
        if (!gaps || $urandom_range(0, 2) != 0) begin
          i_valid = 1'b1;
          pend    = 1;
          pg      = g;
          pe      = (p == 0) ? '0 : mdl[g];
          s++;
          g++;
          if (g == G) begin
            g = 0;
            p++;
          end
        end
      end else begin
        i_valid = 1'b1;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    chk1("job_timeout", fin, 1'b1);
    chk1("busy_drain", o_busy, 1'b1);
    chk1("valid_drain", o_out_valid, 1'b1);
  endtask

  task automatic drain(input int G, input int stall0);
    int st;
    for (int k = 0; k < G; k++) begin
      st = (k == 0) ? stall0 : $urandom_range(0, 2);
      i_out_ready = 1'b0;
      for (int j = 0; j < st; j++) begin
        chk1("drain_hold_valid", o_out_valid, 1'b1);
        chk("drain_hold_data", o_out_data, relu(mdl[k]));
        @(negedge clk);
      end
      i_out_ready = 1'b1;
      chk1("drain_valid", o_out_valid, 1'b1);
      chk("drain_data", o_out_data, relu(mdl[k]));
      @(negedge clk);
    end
    i_out_ready = 1'b0;
    chk1("done_pulse", o_done, 1'b1);
    chk1("busy_idle", o_busy, 1'b0);
    chk1("valid_idle", o_out_valid, 1'b0);
    chk("data_idle", o_out_data, '0);
    @(negedge clk);
    chk1("done_clear", o_done, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int G, P;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_num_groups = '0;
    i_num_passes = '0;
    i_valid      = 1'b0;
    i_res        = '0;
    i_out_ready  = 1'b0;
    mode         = 0;
    addc         = 0;
    fixed_res    = '0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_valid", o_out_valid, 1'b0);
    chk("rst_psum", o_psum, '0);
    chk("rst_data", o_out_data, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single group, single pass, lane0 result 5.
    mode = 2;
    fixed_res = '0;
    fixed_res[15:0] = 16'd5;
    run_job(1, 1, 0, 0);
    drain(1, 0);

    // G=2, P=3, res = psum + 1: every lane ends at 3.
    mode = 0; addc = 1;
    run_job(2, 3, 0, 0);
    drain(2, 0);

    // G=1 back-to-back, res = psum + 2; drain stalled 5 cycles.
    addc = 2;
    run_job(1, 4, 0, 0);
    drain(1, 5);

    // Negative lane on the drain path.
    mode = 2;
    fixed_res = rand_word();
    fixed_res[15:0] = 16'hFFFD;
    run_job(1, 1, 0, 0);
    drain(1, 0);

    // Reset in the middle of pass 1, then a fresh single-pass job.
    mode = 1;
    run_job(2, 3, 0, 3);
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_busy", o_busy, 1'b0);
    chk1("midrst_valid", o_out_valid, 1'b0);
    chk1("midrst_done", o_done, 1'b0);
    chk("midrst_psum", o_psum, '0);
    chk("midrst_data", o_out_data, '0);
    rst = 1'b0;
    @(negedge clk);
    chk1("postrst_busy", o_busy, 1'b0);
    run_job(2, 1, 0, 0);
    drain(2, 0);

    // Full depth and long pass count.
    mode = 1;
    run_job(16, 2, 1, 0);
    drain(16, 1);
    mode = 0; addc = 7;
    run_job(1, 255, 0, 0);
    drain(1, 0);

    // Randomized jobs with gaps, stray starts and drain stalls.
    for (int t = 0; t < 8; t++) begin
      G    = $urandom_range(1, 16);
      P    = $urandom_range(1, 4);
      mode = $urandom_range(0, 1);
      addc = $urandom_range(0, 65535);
      run_job(G, P, 1, 0);
      drain(G, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
